// File: rtl/sm4_result_reader.sv
// rtl/sm4_result_reader.sv - two-block result buffer serializing SM4 128-bit outputs as 32-bit words
module sm4_result_reader (
    input  logic         CLK,
    input  logic         REST,
    input  logic         SAVE_DATA,
    input  logic [127:0] RESULT_31,
    input  logic         RD_READY,
    input  logic         CLR_OVF,
    output logic         RD_VALID,
    output logic [31:0]  RD_DATA,
    output logic         RD_LAST,
    output logic         FULL,
    output logic         OVERFLOW
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic [127:0] buf_q [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   word_idx;
    logic         ovf_q;

    logic         xfer;
    logic         pop;
    logic         push;
    logic         drop;
    logic [127:0] cur_block;

    assign RD_VALID = (state == SEND);
    assign xfer     = RD_VALID & RD_READY;
    assign pop      = xfer & (word_idx == 2'd3);

    // A full buffer still takes a new block when the head block retires on the same edge.
    assign push     = SAVE_DATA & ((count != 2'd2) | pop);
    assign drop     = SAVE_DATA & (count == 2'd2) & ~pop;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (push) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (pop && (count == 2'd1) && !push) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr <= 1'b0;
        end else if (push) begin
            buf_q[wr_ptr] <= RESULT_31;
            wr_ptr        <= ~wr_ptr;
        end
    end

    // word_idx wraps 3->0 by natural 2-bit overflow, coinciding with the pop.
    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            rd_ptr   <= 1'b0;
            word_idx <= 2'd0;
        end else begin
            if (xfer) begin
                word_idx <= word_idx + 2'd1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Set has priority over clear so a drop coinciding with CLR_OVF is never lost.
    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (CLR_OVF) begin
            ovf_q <= 1'b0;
        end
    end

    assign cur_block = buf_q[rd_ptr];

    always_comb begin
        RD_DATA = '0;
        if (RD_VALID) begin
            case (word_idx)
                2'd0:    RD_DATA = cur_block[127:96];
                2'd1:    RD_DATA = cur_block[95:64];
                2'd2:    RD_DATA = cur_block[63:32];
                default: RD_DATA = cur_block[31:0];
            endcase
        end
    end

    assign RD_LAST  = RD_VALID & (word_idx == 2'd3);
    assign FULL     = (count == 2'd2);
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_sm4_result_reader.sv
// tb/tb_sm4_result_reader.sv - directed self-checking bench for sm4_result_reader
module tb_sm4_result_reader;

    logic         CLK;
    logic         REST;
    logic         SAVE_DATA;
    logic [127:0] RESULT_31;
    logic         RD_READY;
    logic         CLR_OVF;
    logic         RD_VALID;
    logic [31:0]  RD_DATA;
    logic         RD_LAST;
    logic         FULL;
    logic         OVERFLOW;

    int vectors;
    int miscompares;

    logic [127:0] blk_a;
    logic [127:0] blk_b;
    logic [127:0] blk_c;
    logic [127:0] blk_d;
    logic [31:0]  wa [4];
    logic [31:0]  wb [4];
    logic [31:0]  wc [4];

    sm4_result_reader dut (
        .CLK       (CLK),
        .REST      (REST),
        .SAVE_DATA (SAVE_DATA),
        .RESULT_31 (RESULT_31),
        .RD_READY  (RD_READY),
        .CLR_OVF   (CLR_OVF),
        .RD_VALID  (RD_VALID),
        .RD_DATA   (RD_DATA),
        .RD_LAST   (RD_LAST),
        .FULL      (FULL),
        .OVERFLOW  (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        REST = 1'b0; SAVE_DATA = 1'b0; RESULT_31 = '0; RD_READY = 1'b0; CLR_OVF = 1'b0;
        #2;
        vectors++;
        if (RD_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", RD_VALID); end
        vectors++;
        if (RD_DATA !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want 00000000", RD_DATA); end
        vectors++;
        if (RD_LAST !== 1'b0) begin miscompares++; $display("FAIL reset_last got %b want 0", RD_LAST); end
        vectors++;
        if (FULL !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", FULL); end
        vectors++;
        if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", OVERFLOW); end
        tick();
        tick();
        REST = 1'b1;
    endtask

    task automatic test_single_block();
        RD_READY = 1'b1;
        SAVE_DATA = 1'b1; RESULT_31 = blk_a;
        tick();
        SAVE_DATA = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (RD_VALID !== 1'b1) begin miscompares++; $display("FAIL single_valid w%0d got %b want 1", i, RD_VALID); end
            vectors++;
            if (RD_DATA !== wa[i]) begin miscompares++; $display("FAIL single_data w%0d got %h want %h", i, RD_DATA, wa[i]); end
            vectors++;
            if (RD_LAST !== (i == 3)) begin miscompares++; $display("FAIL single_last w%0d got %b want %b", i, RD_LAST, (i == 3)); end
            tick();
        end
        vectors++;
        if (RD_VALID !== 1'b0) begin miscompares++; $display("FAIL single_idle got %b want 0", RD_VALID); end
    endtask

    task automatic test_backpressure();
        RD_READY = 1'b1;
        SAVE_DATA = 1'b1; RESULT_31 = blk_a;
        tick();
        SAVE_DATA = 1'b0;
        tick();
        RD_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (RD_VALID !== 1'b1 || RD_DATA !== wa[1] || RD_LAST !== 1'b0)
                begin miscompares++; $display("FAIL bp_hold c%0d got v=%b d=%h l=%b want v=1 d=%h l=0", i, RD_VALID, RD_DATA, RD_LAST, wa[1]); end
            tick();
        end
        RD_READY = 1'b1;
        tick();
        vectors++;
        if (RD_DATA !== wa[2]) begin miscompares++; $display("FAIL bp_next got %h want %h", RD_DATA, wa[2]); end
        tick();
        // word 3 retires with count=1 while the next block arrives
        SAVE_DATA = 1'b1; RESULT_31 = blk_b;
        vectors++;
        if (RD_DATA !== wa[3] || RD_LAST !== 1'b1) begin miscompares++; $display("FAIL bp_last got d=%h l=%b want d=%h l=1", RD_DATA, RD_LAST, wa[3]); end
        tick();
        SAVE_DATA = 1'b0;
        vectors++;
        if (FULL !== 1'b0) begin miscompares++; $display("FAIL c1_swap_full got %b want 0", FULL); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (RD_VALID !== 1'b1 || RD_DATA !== wb[i] || RD_LAST !== (i == 3))
                begin miscompares++; $display("FAIL c1_swap w%0d got v=%b d=%h l=%b want d=%h", i, RD_VALID, RD_DATA, RD_LAST, wb[i]); end
            tick();
        end
        vectors++;
        if (RD_VALID !== 1'b0) begin miscompares++; $display("FAIL c1_swap_idle got %b want 0", RD_VALID); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w;
        RD_READY = 1'b0;
        SAVE_DATA = 1'b1; RESULT_31 = blk_a;
        tick();
        RESULT_31 = blk_b;
        tick();
        vectors++;
        if (FULL !== 1'b1 || OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL ovf_after_b got full=%b ovf=%b want full=1 ovf=0", FULL, OVERFLOW); end
        RESULT_31 = blk_c;
        tick();
        vectors++;
        if (FULL !== 1'b1 || OVERFLOW !== 1'b1) begin miscompares++; $display("FAIL ovf_after_c got full=%b ovf=%b want full=1 ovf=1", FULL, OVERFLOW); end
        RESULT_31 = blk_d; CLR_OVF = 1'b1;
        tick();
        SAVE_DATA = 1'b0; CLR_OVF = 1'b0;
        vectors++;
        if (OVERFLOW !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins got %b want 1", OVERFLOW); end
        RD_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_w = (i < 4) ? wa[i] : wb[i - 4];
            vectors++;
            if (RD_VALID !== 1'b1 || RD_DATA !== exp_w || RD_LAST !== (i % 4 == 3))
                begin miscompares++; $display("FAIL ovf_drain w%0d got v=%b d=%h l=%b want d=%h", i, RD_VALID, RD_DATA, RD_LAST, exp_w); end
            tick();
        end
        vectors++;
        if (RD_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin miscompares++; $display("FAIL ovf_drained got v=%b ovf=%b want v=0 ovf=1", RD_VALID, OVERFLOW); end
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        vectors++;
        if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b want 0", OVERFLOW); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_w;
        RD_READY = 1'b0;
        SAVE_DATA = 1'b1; RESULT_31 = blk_a;
        tick();
        RESULT_31 = blk_b;
        tick();
        SAVE_DATA = 1'b0;
        vectors++;
        if (FULL !== 1'b1) begin miscompares++; $display("FAIL sim_full got %b want 1", FULL); end
        RD_READY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_w = (i < 4) ? wa[i] : (i < 8) ? wb[i - 4] : wc[i - 8];
            vectors++;
            if (RD_VALID !== 1'b1 || RD_DATA !== exp_w || RD_LAST !== (i % 4 == 3))
                begin miscompares++; $display("FAIL sim_word w%0d got v=%b d=%h l=%b want d=%h", i, RD_VALID, RD_DATA, RD_LAST, exp_w); end
            if (i == 3) begin
                SAVE_DATA = 1'b1; RESULT_31 = blk_c;
            end
            tick();
            SAVE_DATA = 1'b0;
            if (i == 3) begin
                vectors++;
                if (OVERFLOW !== 1'b0 || FULL !== 1'b1) begin miscompares++; $display("FAIL sim_accept got ovf=%b full=%b want ovf=0 full=1", OVERFLOW, FULL); end
            end
        end
        vectors++;
        if (RD_VALID !== 1'b0 || FULL !== 1'b0) begin miscompares++; $display("FAIL sim_end got v=%b full=%b want 0 0", RD_VALID, FULL); end
    endtask

    task automatic test_reset_mid();
        RD_READY = 1'b1;
        SAVE_DATA = 1'b1; RESULT_31 = blk_a;
        tick();
        SAVE_DATA = 1'b1; RESULT_31 = blk_b;
        tick();
        SAVE_DATA = 1'b0;
        tick();
        vectors++;
        if (RD_DATA !== wa[2]) begin miscompares++; $display("FAIL rmid_pre got %h want %h", RD_DATA, wa[2]); end
        #2;
        REST = 1'b0;
        #1;
        vectors++;
        if (RD_VALID !== 1'b0 || RD_DATA !== 32'h0 || RD_LAST !== 1'b0 || FULL !== 1'b0 || OVERFLOW !== 1'b0)
            begin miscompares++; $display("FAIL rmid_async got v=%b d=%h l=%b f=%b o=%b want all 0", RD_VALID, RD_DATA, RD_LAST, FULL, OVERFLOW); end
        tick();
        @(negedge CLK);
        REST = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (RD_VALID !== 1'b0) begin miscompares++; $display("FAIL rmid_quiet c%0d got %b want 0", i, RD_VALID); end
            tick();
        end
        SAVE_DATA = 1'b1; RESULT_31 = blk_c;
        tick();
        SAVE_DATA = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (RD_VALID !== 1'b1 || RD_DATA !== wc[i]) begin miscompares++; $display("FAIL rmid_new w%0d got v=%b d=%h want %h", i, RD_VALID, RD_DATA, wc[i]); end
            tick();
        end
        vectors++;
        if (RD_VALID !== 1'b0) begin miscompares++; $display("FAIL rmid_end got %b want 0", RD_VALID); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        blk_a = 128'h681edf34d206965e86b3e94f536e4246;
        blk_b = 128'h0123456789abcdeffedcba9876543210;
        blk_c = 128'h00112233445566778899aabbccddeeff;
        blk_d = 128'hdeadbeefcafef00d0badc0de12345678;
        wa = '{32'h681edf34, 32'hd206965e, 32'h86b3e94f, 32'h536e4246};
        wb = '{32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
        wc = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

        test_reset();
        test_single_block();
        test_backpressure();
        test_overflow();
        test_simultaneous();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sm4_result_reader.md
SM4_RESULT_READER -- requirements
Module: sm4_result_reader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; the ports are named CLK and REST as elsewhere in the SM4 datapath.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 REST  input  1  async active-low reset; 0 clears all state immediately.
REQ-004 SAVE_DATA  input  1  one-cycle strobe from the SM4 core: RESULT_31 holds a finished 128-bit block.
REQ-005 RESULT_31  input  128  ciphertext/plaintext block; sampled only when SAVE_DATA=1.
REQ-006 RD_READY  input  1  consumer accepts the current word.
REQ-007 CLR_OVF  input  1  synchronous clear of OVERFLOW.
REQ-008 RD_VALID  output  1  RD_DATA holds a valid word.
REQ-009 RD_DATA  output  32  current result word.
REQ-010 RD_LAST  output  1  current word is word 3 (final) of its block.
REQ-011 FULL  output  1  both buffer entries occupied.
REQ-012 OVERFLOW  output  1  sticky flag: a block was dropped.

Function
REQ-013 SHALL buffer up to 2 complete 128-bit blocks in FIFO order (2-entry, 1-bit write/read pointers, 2-bit count 0..2).
REQ-014 SHALL serialize each block as 4 words, most significant first: [127:96], [95:64], [63:32], [31:0].
REQ-015 Word transfer SHALL occur on a rising edge where RD_VALID=1 and RD_READY=1; RD_DATA/RD_LAST SHALL stay stable while RD_VALID=1 and RD_READY=0.
REQ-016 RD_VALID SHALL be registered; with count=0, a SAVE_DATA at edge N SHALL give RD_VALID=1 and RD_DATA=RESULT_31[127:96] in the cycle after edge N (1-cycle latency).
REQ-017 FSM SHALL have states IDLE (count=0, RD_VALID=0) and SEND (count>=1, RD_VALID=1); IDLE->SEND on push; SEND->IDLE on transfer of word 3 when count=1 and no simultaneous push; otherwise remain.
REQ-018 2-bit word index SHALL increment on each transfer, wrap 3->0 on transfer of word 3, and the read pointer and count SHALL advance (pop) on that same edge.
REQ-019 After a pop with count still >=1, next block's word 0 SHALL be presented the following cycle with no bubble.
REQ-020 SAVE_DATA with count=2 and no pop on the same edge SHALL drop the block, leave buffer contents unchanged, and set OVERFLOW=1.
REQ-021 SAVE_DATA with count=2 on the same edge as a pop (word-3 transfer) SHALL be accepted; count stays 2; OVERFLOW unchanged.
REQ-022 SAVE_DATA and pop on the same edge with count=1 SHALL leave count=1 and present the new block next cycle.
REQ-023 FULL SHALL equal (count==2), combinationally from registered count.
REQ-024 OVERFLOW SHALL remain 1 until CLR_OVF=1 at an edge; if CLR_OVF and an overflow condition coincide, OVERFLOW SHALL be 1 (set wins).
REQ-025 SAVE_DATA held high for k cycles SHALL be treated as k separate pushes.

Reset
REQ-026 While REST=0: RD_VALID=0, RD_DATA=0, RD_LAST=0, FULL=0, OVERFLOW=0, count=0, pointers=0, word index=0, FSM=IDLE.
REQ-027 Reset asserted mid-block SHALL discard all buffered data; no partial block is output after release.
REQ-028 First push SHALL be accepted at the first rising edge after REST deasserts.

Verification
REQ-029 Single block: RESULT_31=681edf34d206965e86b3e94f536e4246, SAVE_DATA 1 cycle, RD_READY=1 -> words 681edf34, d206965e, 86b3e94f, 536e4246 on 4 consecutive cycles, RD_LAST on the 4th, then RD_VALID=0.
REQ-030 Backpressure: RD_READY=0 for 5 cycles after word 1 appears -> RD_DATA holds d206965e, RD_VALID=1 throughout, no word skipped.
REQ-031 Overflow: 3 pushes (A,B,C) with RD_READY=0 -> FULL=1 after B, OVERFLOW=1 after C; output A then B only; CLR_OVF pulse -> OVERFLOW=0.
REQ-032 Simultaneous: count=2, push C on the edge A's word 3 transfers -> C accepted, OVERFLOW=0, output order A, B, C back-to-back.
REQ-033 Reset mid-operation: REST=0 after word 2 of a block -> all outputs 0 immediately; after release RD_VALID stays 0 until next SAVE_DATA.
